// File: rtl/regfile_write_arbiter_if.sv
// Register-file write arbiter bundle: wb/md/io write requests, md issue,
// busy scoreboard and the register-file write-port controls.
interface regfile_write_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready;
  logic        io_valid;
  logic [4:0]  io_reg;
  logic [31:0] io_data;
  logic        io_ready;
  logic        md_issue;
  logic [4:0]  md_issue_reg;
  logic [31:0] busy_mask;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  modport slave (
    input  wb_we, wb_reg, wb_data,
    input  md_valid, md_reg, md_data,
    output md_ready,
    input  io_valid, io_reg, io_data,
    output io_ready,
    input  md_issue, md_issue_reg,
    output busy_mask,
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg
  );

  modport master (
    output wb_we, wb_reg, wb_data,
    output md_valid, md_reg, md_data,
    input  md_ready,
    output io_valid, io_reg, io_data,
    input  io_ready,
    output md_issue, md_issue_reg,
    input  busy_mask,
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port: wb > multdiv FIFO > I/O holding reg,
// and tracks registers awaiting multdiv results in busy_mask.
// Ports: clock, ctrl_reset_n (async, active-low), bus (slave modport).
// Define REGFILE_ARB_STARVE_EN to let a starved I/O write outrank the FIFO.
module regfile_write_arbiter #(
  parameter int MD_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input logic                     clock,
  input logic                     ctrl_reset_n,
  regfile_write_arbiter_if.slave  bus
);
  localparam int PW = $clog2(MD_DEPTH);
  localparam int CW = PW + 1;

  if (MD_DEPTH < 2 || MD_DEPTH > 8 ||
      (MD_DEPTH & (MD_DEPTH - 1)) != 0 ||
      STARVE_MAX < 1) begin : g_bad_param
    $error("regfile_write_arbiter: bad parameters");
  end

  logic [4:0]  fifo_reg_q  [MD_DEPTH];
  logic [4:0]  fifo_reg_d  [MD_DEPTH];
  logic [31:0] fifo_data_q [MD_DEPTH];
  logic [31:0] fifo_data_d [MD_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic        io_held_q, io_held_d;
  logic [4:0]  io_reg_q, io_reg_d;
  logic [31:0] io_data_q, io_data_d;

  logic [31:0] busy_q, busy_d;
  logic        we_q, we_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;

  logic        full, empty;
  logic        md_acc, io_acc;
  logic        io_first;
  logic        gnt_wb, gnt_md, gnt_io;
  logic        any_gnt;
  logic [4:0]  sel_reg;
  logic [31:0] sel_data;
  logic [31:0] set_v, clr_v;

  assign full  = count_q == CW'(MD_DEPTH);
  assign empty = count_q == '0;

  assign md_acc = bus.md_valid && !full;
  assign io_acc = bus.io_valid && !io_held_q;

`ifdef REGFILE_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q, starve_d;

  assign io_first = io_held_q && (starve_q == SW'(STARVE_MAX));

  // Only losses to the FIFO count; losing to wb holds the count.
  always_comb begin
    starve_d = starve_q;
    if (!io_held_q || gnt_io)
      starve_d = '0;
    else if (gnt_md)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) starve_q <= '0;
    else               starve_q <= starve_d;
  end
`else
  assign io_first = 1'b0;
`endif

  assign gnt_wb = bus.wb_we;
  assign gnt_io = !bus.wb_we && io_held_q &&
                  (io_first || empty);
  assign gnt_md = !bus.wb_we && !empty && !gnt_io;
  assign any_gnt = gnt_wb || gnt_md || gnt_io;

  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    unique case (1'b1)
      gnt_wb: begin
        sel_reg  = bus.wb_reg;
        sel_data = bus.wb_data;
      end
      gnt_md: begin
        sel_reg  = fifo_reg_q[rd_ptr_q];
        sel_data = fifo_data_q[rd_ptr_q];
      end
      gnt_io: begin
        sel_reg  = io_reg_q;
        sel_data = io_data_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    fifo_reg_d  = fifo_reg_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (md_acc) begin
      fifo_reg_d[wr_ptr_q]  = bus.md_reg;
      fifo_data_d[wr_ptr_q] = bus.md_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (gnt_md)
      rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(md_acc) - CW'(gnt_md);
  end

  always_comb begin
    io_held_d = (io_held_q && !gnt_io) || io_acc;
    io_reg_d  = io_acc ? bus.io_reg  : io_reg_q;
    io_data_d = io_acc ? bus.io_data : io_data_q;
  end

  // Set beats clear on the same bit; bit 0 is never busy.
  always_comb begin
    set_v  = bus.md_issue ? (32'b1 << bus.md_issue_reg) : '0;
    clr_v  = gnt_md ? (32'b1 << fifo_reg_q[rd_ptr_q]) : '0;
    busy_d = ((busy_q & ~clr_v) | set_v) & ~32'h1;
  end

  always_comb begin
    we_d    = any_gnt && (sel_reg != 5'd0);
    wreg_d  = any_gnt ? sel_reg  : wreg_q;
    wdata_d = any_gnt ? sel_data : wdata_q;
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < MD_DEPTH; i++) begin
        fifo_reg_q[i]  <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      io_held_q <= 1'b0;
      io_reg_q  <= '0;
      io_data_q <= '0;
      busy_q    <= '0;
      we_q      <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
    end else begin
      fifo_reg_q  <= fifo_reg_d;
      fifo_data_q <= fifo_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      io_held_q   <= io_held_d;
      io_reg_q    <= io_reg_d;
      io_data_q   <= io_data_d;
      busy_q      <= busy_d;
      we_q        <= we_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
    end
  end

  assign bus.md_ready         = !full;
  assign bus.io_ready         = !io_held_q;
  assign bus.busy_mask        = busy_q;
  assign bus.ctrl_writeEnable = we_q;
  assign bus.ctrl_writeReg    = wreg_q;
  assign bus.data_writeReg    = wdata_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected port writes are queued
// as stimulus is driven and popped whenever the write port fires.
module tb_regfile_write_arbiter;
  logic clock;
  logic ctrl_reset_n;
  int   checks;
  int   errors;
  logic [36:0] exp_q [$];

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(
    .MD_DEPTH   (2),
    .STARVE_MAX (4)
  ) dut (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .bus          (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] r,
                      input logic [31:0] d);
    exp_q.push_back({r, d});
  endtask

  task automatic drive_wb(input logic [4:0] r,
                          input logic [31:0] d);
    bus.wb_we   = 1'b1;
    bus.wb_reg  = r;
    bus.wb_data = d;
    if (r != 5'd0) push(r, d);
  endtask

  // Scoreboard: every write-port pulse must match the queue head.
  always @(negedge clock) begin
    if (bus.ctrl_writeEnable === 1'b1) begin
      logic [36:0] e;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL wr_unexpected: got reg %0d data %h want none",
               bus.ctrl_writeReg, bus.data_writeReg);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert ({bus.ctrl_writeReg, bus.data_writeReg} === e)
        else begin
          errors++;
          $error("FAIL wr_order: got %0d/%h want %0d/%h",
                 bus.ctrl_writeReg, bus.data_writeReg,
                 e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    int k;
    logic acc;
    checks = 0;
    errors = 0;
    ctrl_reset_n     = 1'b0;
    bus.wb_we        = 1'b0;
    bus.wb_reg       = '0;
    bus.wb_data      = '0;
    bus.md_valid     = 1'b0;
    bus.md_reg       = '0;
    bus.md_data      = '0;
    bus.io_valid     = 1'b0;
    bus.io_reg       = '0;
    bus.io_data      = '0;
    bus.md_issue     = 1'b0;
    bus.md_issue_reg = '0;
    tick();
    tick();
    chk("rst_we", bus.ctrl_writeEnable, 0);
    chk("rst_reg", bus.ctrl_writeReg, 0);
    chk("rst_data", bus.data_writeReg, 0);
    chk("rst_busy", bus.busy_mask, 0);
    chk("rst_md_ready", bus.md_ready, 1);
    chk("rst_io_ready", bus.io_ready, 1);
    ctrl_reset_n = 1'b1;
    tick();

    // Plain writeback.
    drive_wb(5'd5, 32'hDEADBEEF);
    tick();
    bus.wb_we = 1'b0;
    chk("wb_we", bus.ctrl_writeEnable, 1);
    chk("wb_reg", bus.ctrl_writeReg, 5);
    chk("wb_data", bus.data_writeReg, 32'hDEADBEEF);
    tick();
    chk("wb_we_off", bus.ctrl_writeEnable, 0);
    chk("wb_hold_reg", bus.ctrl_writeReg, 5);

    // Scoreboard set, wb priority, clear on md grant.
    bus.md_issue     = 1'b1;
    bus.md_issue_reg = 5'd9;
    tick();
    bus.md_issue = 1'b0;
    chk("busy9_set", bus.busy_mask[9], 1);
    drive_wb(5'd1, 32'h100);
    bus.md_valid = 1'b1;
    bus.md_reg   = 5'd9;
    bus.md_data  = 32'h12;
    tick();
    bus.md_valid = 1'b0;
    chk("busy9_a", bus.busy_mask[9], 1);
    drive_wb(5'd2, 32'h200);
    tick();
    chk("busy9_b", bus.busy_mask[9], 1);
    drive_wb(5'd3, 32'h300);
    tick();
    chk("busy9_c", bus.busy_mask[9], 1);
    bus.wb_we = 1'b0;
    push(5'd9, 32'h12);
    tick();
    chk("md9_we", bus.ctrl_writeEnable, 1);
    chk("md9_reg", bus.ctrl_writeReg, 9);
    chk("busy9_clr", bus.busy_mask[9], 0);
    tick();
    chk("md9_we_off", bus.ctrl_writeEnable, 0);

    // FIFO fills behind wb, then drains in order.
    drive_wb(5'd10, 32'hA0);
    bus.md_valid = 1'b1;
    bus.md_reg   = 5'd11;
    bus.md_data  = 32'hB1;
    chk("fill_ready0", bus.md_ready, 1);
    tick();
    drive_wb(5'd10, 32'hA1);
    bus.md_reg  = 5'd12;
    bus.md_data = 32'hB2;
    tick();
    chk("fill_full", bus.md_ready, 0);
    drive_wb(5'd10, 32'hA2);
    bus.md_reg  = 5'd13;
    bus.md_data = 32'hB3;
    tick();
    chk("fill_held", bus.md_ready, 0);
    drive_wb(5'd10, 32'hA3);
    tick();
    bus.wb_we = 1'b0;
    push(5'd11, 32'hB1);
    tick();
    chk("drain1_we", bus.ctrl_writeEnable, 1);
    chk("drain1_reg", bus.ctrl_writeReg, 11);
    chk("drain_ready", bus.md_ready, 1);
    push(5'd12, 32'hB2);
    tick();
    bus.md_valid = 1'b0;
    chk("drain2_reg", bus.ctrl_writeReg, 12);
    push(5'd13, 32'hB3);
    tick();
    chk("drain3_we", bus.ctrl_writeEnable, 1);
    chk("drain3_reg", bus.ctrl_writeReg, 13);
    tick();
    chk("drain_idle", bus.ctrl_writeEnable, 0);

    // md beats io when accepted together.
    bus.io_valid = 1'b1;
    bus.io_reg   = 5'd20;
    bus.io_data  = 32'h1;
    bus.md_valid = 1'b1;
    bus.md_reg   = 5'd3;
    bus.md_data  = 32'h7;
    tick();
    bus.io_valid = 1'b0;
    bus.md_valid = 1'b0;
    chk("io_held", bus.io_ready, 0);
    push(5'd3, 32'h7);
    push(5'd20, 32'h1);
    tick();
    chk("mdio_first", bus.ctrl_writeReg, 3);
    chk("io_still", bus.io_ready, 0);
    tick();
    chk("mdio_second", bus.ctrl_writeReg, 20);
    chk("io_free", bus.io_ready, 1);
    tick();
    chk("mdio_idle", bus.ctrl_writeEnable, 0);

    // Register 0 from every source.
    drive_wb(5'd0, 32'h11);
    tick();
    bus.wb_we = 1'b0;
    chk("r0_wb", bus.ctrl_writeEnable, 0);
    bus.md_valid = 1'b1;
    bus.md_reg   = 5'd0;
    bus.md_data  = 32'h5;
    tick();
    bus.md_valid = 1'b0;
    tick();
    chk("r0_md", bus.ctrl_writeEnable, 0);
    chk("r0_md_deq", bus.md_ready, 1);
    bus.io_valid = 1'b1;
    bus.io_reg   = 5'd0;
    bus.io_data  = 32'h6;
    tick();
    bus.io_valid = 1'b0;
    chk("r0_io_held", bus.io_ready, 0);
    tick();
    chk("r0_io", bus.ctrl_writeEnable, 0);
    chk("r0_io_deq", bus.io_ready, 1);
    bus.md_issue     = 1'b1;
    bus.md_issue_reg = 5'd0;
    tick();
    bus.md_issue = 1'b0;
    chk("r0_busy", bus.busy_mask, 0);

    // Reset mid-operation discards the queued md write.
    bus.md_issue     = 1'b1;
    bus.md_issue_reg = 5'd7;
    bus.md_valid     = 1'b1;
    bus.md_reg       = 5'd7;
    bus.md_data      = 32'h77;
    tick();
    bus.md_issue = 1'b0;
    bus.md_valid = 1'b0;
    chk("mid_busy", bus.busy_mask, 32'h80);
    ctrl_reset_n = 1'b0;
    #1;
    chk("mid_busy_clr", bus.busy_mask, 0);
    chk("mid_ready", bus.md_ready, 1);
    tick();
    tick();
    chk("mid_we", bus.ctrl_writeEnable, 0);
    ctrl_reset_n = 1'b1;
    tick();
    chk("post_we_a", bus.ctrl_writeEnable, 0);
    tick();
    chk("post_we_b", bus.ctrl_writeEnable, 0);

    // I/O pending against a continuous md stream.
`ifdef REGFILE_ARB_STARVE_EN
    for (int i = 0; i < 4; i++) push(5'd4, 32'h400 + i);
    push(5'd21, 32'h55);
    for (int i = 4; i < 8; i++) push(5'd4, 32'h400 + i);
`else
    for (int i = 0; i < 8; i++) push(5'd4, 32'h400 + i);
    push(5'd21, 32'h55);
`endif
    bus.io_valid = 1'b1;
    bus.io_reg   = 5'd21;
    bus.io_data  = 32'h55;
    k = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      bus.md_valid = 1'b1;
      bus.md_reg   = 5'd4;
      bus.md_data  = 32'h400 + k;
      acc = bus.md_ready;
      tick();
      bus.io_valid = 1'b0;
      if (acc) k++;
    end
    bus.md_valid = 1'b0;
    chk("stream_done", k, 8);
    for (int c = 0; c < 6; c++) tick();
    chk("queue_empty", exp_q.size(), 0);
    chk("end_io_ready", bus.io_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
